// File: rtl/sync_fifo_fwft_if.sv
// sync_fifo_fwft_if: handshake and status bundle for sync_fifo_fwft.
// master drives flush/write/data_write/read; slave (the FIFO) drives data_read,
// full/empty, almost_full/almost_empty, data_count, overflow/underflow, data_read_valid.
interface sync_fifo_fwft_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 1000
);
  localparam int CW = $clog2(DEPTH + 1);
  logic flush;
  logic write;
  logic [DATA_WIDTH-1:0] data_write;
  logic read;
  logic [DATA_WIDTH-1:0] data_read;
  logic full;
  logic empty;
  logic almost_full;
  logic almost_empty;
  logic [CW-1:0] data_count;
  logic overflow;
  logic underflow;
  logic data_read_valid;
  modport master (
    output flush, write, data_write, read,
    input data_read, full, empty, almost_full, almost_empty, data_count,
    overflow, underflow, data_read_valid
  );
  modport slave (
    input flush, write, data_write, read,
    output data_read, full, empty, almost_full, almost_empty, data_count,
    overflow, underflow, data_read_valid
  );
endinterface

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: single-clock FIFO, any depth, FWFT or standard read, thresholds, flush, sticky errors.
// clk/rst: clock and async active-high reset; bus (slave): write/read handshake,
// flush, data, occupancy count and status flags.
module sync_fifo_fwft #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 1000,
  parameter int FWFT = 1,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input logic clk,
  input logic rst,
  sync_fifo_fwft_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  if (DEPTH < 2 || AF_LEVEL < 1 || AF_LEVEL > DEPTH || AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_cfg
    $error("sync_fifo_fwft: DEPTH, AF_LEVEL or AE_LEVEL out of range");
  end
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic [DATA_WIDTH-1:0] dout;
  logic full, empty, almost_full, almost_empty, overflow, underflow, valid;
  logic we, re;
  always_comb begin
    we = bus.write && !full && !bus.flush;
    re = bus.read && !empty && !bus.flush;
    count_next = count + CW'(we) - CW'(re);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      full <= 1'b0;
      empty <= 1'b1;
      almost_full <= 1'b0;
      almost_empty <= 1'b1;
      overflow <= 1'b0;
      underflow <= 1'b0;
      valid <= 1'b0;
      dout <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      full <= 1'b0;
      empty <= 1'b1;
      almost_full <= 1'b0;
      almost_empty <= 1'b1;
      overflow <= 1'b0;
      underflow <= 1'b0;
      valid <= 1'b0;
    end else begin
      if (we) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (re) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (re) dout <= mem[rd_ptr];
      count <= count_next;
      full <= count_next == CW'(DEPTH);
      empty <= count_next == '0;
      almost_full <= count_next >= CW'(AF_LEVEL);
      almost_empty <= count_next <= CW'(AE_LEVEL);
      overflow <= overflow | (bus.write & full);
      underflow <= underflow | (bus.read & empty);
      valid <= re;
    end
  end
  always_ff @(posedge clk) if (we) mem[wr_ptr] <= bus.data_write;
  // FWFT output is masked while empty so stale or unreset RAM never shows on data_read
  assign bus.data_read = (FWFT != 0) ? (empty ? '0 : mem[rd_ptr]) : dout;
  assign bus.data_read_valid = (FWFT != 0) ? !empty : valid;
  assign bus.full = full;
  assign bus.empty = empty;
  assign bus.almost_full = almost_full;
  assign bus.almost_empty = almost_empty;
  assign bus.data_count = count;
  assign bus.overflow = overflow;
  assign bus.underflow = underflow;
endmodule

// File: doc/sync_fifo_fwft.md
Name: sync_fifo_fwft

Overview:
Single-clock, parametrised FIFO for intra-domain buffering in the pixel/CNN datapath, e.g. line-buffer staging between the frame reader and the convolution engine.
- Generalises the existing dual-clock FIFO: arbitrary (non-power-of-two) depth, selectable first-word-fall-through or standard read mode.
- Adds programmable almost-full/almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags.
- Exact occupancy count is available every cycle; there is no synchroniser lag.

Parameters:
- DATA_WIDTH, 8, width of data_write/data_read.
- DEPTH, 1000, number of entries; any integer >= 2, not restricted to powers of two.
- FWFT, 1, 1 = first-word-fall-through, 0 = standard mode with 1-cycle read latency.
- AF_LEVEL, DEPTH-4, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL.
- (derived) CW = clog2(DEPTH+1), width of the count; AW = clog2(DEPTH), width of the pointers.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous reset, active-high.
- flush  in  1  synchronous clear of all contents.
- write  in  1  write request.
- data_write  in  DATA_WIDTH  write data.
- read  in  1  read request (pop).
- data_read  out  DATA_WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0 (FWFT=1: data_read invalid).
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- data_count  out  CW  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.
- data_read_valid  out  1  FWFT=0 only: data_read valid this cycle; tied to !empty when FWFT=1.

Behaviour:
- Reset (async assert, sync release): wr_ptr=0, rd_ptr=0, count=0. Outputs: empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, data_read_valid=0, data_read=0. RAM contents are not reset.
- Accept rules:
  - we = write && !full.
  - re = read && !empty.
  - Both evaluated on the pre-edge count.
  - Write when full is dropped. Read when empty is dropped.
  - There is no write-through: when empty, a simultaneous write+read accepts the write and rejects the read.
- Pointers: increment by 1 on accept and wrap from DEPTH-1 to 0. A power-of-two depth must not be assumed.
- Count: count_next = count + we - re, computed at CW bits. Simultaneous accepted read and write leaves count unchanged.
- Flags: full, empty, almost_full and almost_empty are registered from count_next. They are valid the cycle after the causing edge, with no extra latency. data_count = registered count.
- FWFT=1:
  - data_read = mem[rd_ptr] (asynchronous-read RAM).
  - The first word written into an empty FIFO appears on data_read, with empty=0, in the cycle after the write edge.
  - read acts as an acknowledge/pop; the next word is presented the cycle after the pop.
- FWFT=0:
  - data_read is registered: it is loaded with mem[rd_ptr] on an accepted read and holds otherwise.
  - data_read_valid=1 for exactly the one cycle after each accepted read.
- Errors:
  - overflow is set on (write && full); underflow is set on (read && empty).
  - Both are sticky and cleared only by rst or flush.
  - The rejected operation does not alter pointers, count or RAM.
- Flush:
  - Takes priority over write and read in the same cycle. Both are ignored.
  - Next cycle: pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, data_read_valid=0. data_read holds its value in FWFT=0 mode.
- Full boundary: with count==DEPTH, read+write accepts only the read; count becomes DEPTH-1.
- Thresholds: AF_LEVEL must be in 1..DEPTH and AE_LEVEL in 0..DEPTH-1. An out-of-range setting is an elaboration error, checked by a generate-time assertion.
- Reset mid-operation: all state returns to reset values immediately. The RAM contents are garbage afterwards but never visible, because empty=1.

Test Plan:
- DEPTH=6, FWFT=1: write 0x11..0x16 on consecutive cycles → empty=0 one cycle after the first write; full=1 one cycle after the 6th write; data_count=6. A 7th write → overflow=1, count stays 6, data_read stays 0x11.
- Wrap: with DEPTH=6, push 4, pop 4, push 5 more (0xA0..0xA4) → pointers wrap past index 5. Pops return 0xA0..0xA4 in order; empty=1 after the last pop.
- Simultaneous: at count=3, assert write+read for 10 cycles → data_count stays 3 and the output order is preserved. At count=0, write+read in the same cycle → count=1, underflow=1, data_read=written value next cycle.
- Thresholds: DEPTH=16, AF_LEVEL=12, AE_LEVEL=2. Fill one word per cycle → almost_empty drops when count reaches 3; almost_full rises when count reaches 12; both flags are registered one cycle after the edge.
- FWFT=0: write 0x5A, then read on the next cycle → data_read=0x5A with data_read_valid=1 exactly one cycle after the read edge. data_read_valid=0 on idle cycles.
- Flush and reset: at count=5 with overflow=1, assert flush together with write → next cycle count=0, empty=1, overflow=0, and the write is not stored. Repeat with rst asserted asynchronously mid-burst → outputs return to reset values without waiting for a clock edge.
